// File: rtl/pixel_reader_packed_if.sv
// Pixel reader bus: FIFO block/word handshake on one side, ready/strobe pixel port on the other.
interface pixel_reader_packed_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int SIZE_WIDTH    = 24,
  parameter int CHANNEL_WIDTH = 8
);
  logic                     i_mode;
  logic                     i_swap;
  logic                     i_read_rdy;
  logic                     o_read_act;
  logic [SIZE_WIDTH-1:0]    i_read_size;
  logic [DATA_WIDTH-1:0]    i_read_data;
  logic                     o_read_stb;
  logic [CHANNEL_WIDTH-1:0] o_red;
  logic [CHANNEL_WIDTH-1:0] o_green;
  logic [CHANNEL_WIDTH-1:0] o_blue;
  logic                     o_last;
  logic                     o_pixel_rdy;
  logic                     i_pixel_stb;
  logic                     o_busy;

  modport slave (
    input  i_mode, i_swap, i_read_rdy, i_read_size, i_read_data, i_pixel_stb,
    output o_read_act, o_read_stb, o_red, o_green, o_blue, o_last, o_pixel_rdy, o_busy
  );

  modport master (
    output i_mode, i_swap, i_read_rdy, i_read_size, i_read_data, i_pixel_stb,
    input  o_read_act, o_read_stb, o_red, o_green, o_blue, o_last, o_pixel_rdy, o_busy
  );
endinterface

// File: rtl/pixel_reader_packed.sv
// Claims FIFO blocks, unpacks each word into one RGB888 or two RGB565 pixels,
// and streams them as CHANNEL_WIDTH-bit channels with an end-of-block flag.
module pixel_reader_packed #(
  parameter int DATA_WIDTH    = 32,
  parameter int SIZE_WIDTH    = 24,
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pixel_reader_packed_if.slave bus
);
  typedef enum logic {S_IDLE, S_ACT} state_t;
  typedef struct packed {
    logic [CHANNEL_WIDTH-1:0] r;
    logic [CHANNEL_WIDTH-1:0] g;
    logic [CHANNEL_WIDTH-1:0] b;
  } pix_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_in;
  logic [31:0]           word_q;
  logic [SIZE_WIDTH-1:0] count_q;
  logic                  buf_vld, sub_q, mode_q, swap_q, word_last_q;
  pix_t                  pix_q, pix_nxt;
  logic                  last_q, rdy_q;
  logic                  more, final_sub, emit, buf_free, claim, load;
  logic [15:0]           half;
  logic [7:0]            r8, g8, b8;
  logic                  unused_hi;

  assign data_in   = bus.i_read_data;
  assign unused_hi = ^data_in;

  assign more      = count_q < bus.i_read_size;
  assign final_sub = ~mode_q | sub_q;
  assign emit      = buf_vld & (~rdy_q | bus.i_pixel_stb);
  // A word may be refilled in the same cycle its last sub-pixel leaves.
  assign buf_free  = ~buf_vld | (emit & final_sub);

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.i_read_rdy)     state_d = S_ACT;
      S_ACT:  if (!more && !buf_vld)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    claim          = 1'b0;
    load           = 1'b0;
    bus.o_read_act = 1'b0;
    case (state_q)
      S_IDLE: claim = bus.i_read_rdy;
      S_ACT: begin
        bus.o_read_act = 1'b1;
        load           = more & buf_free;
      end
      default: ;
    endcase
    bus.o_read_stb = load;
  end

  // Unpack the current sub-pixel; RGB565 widens by MSB replication, then the
  // top CHANNEL_WIDTH bits of the 8-bit value are kept.
  always_comb begin
    half = (swap_q ^ sub_q) ? word_q[31:16] : word_q[15:0];
    if (mode_q) begin
      r8 = {half[15:11], half[15:13]};
      g8 = {half[10:5],  half[10:9]};
      b8 = {half[4:0],   half[4:2]};
    end else begin
      r8 = word_q[23:16];
      g8 = word_q[15:8];
      b8 = word_q[7:0];
    end
    pix_nxt.r = r8[7 -: CHANNEL_WIDTH];
    pix_nxt.g = g8[7 -: CHANNEL_WIDTH];
    pix_nxt.b = b8[7 -: CHANNEL_WIDTH];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word_q      <= '0;
      count_q     <= '0;
      buf_vld     <= 1'b0;
      sub_q       <= 1'b0;
      mode_q      <= 1'b0;
      swap_q      <= 1'b0;
      word_last_q <= 1'b0;
      pix_q       <= '0;
      last_q      <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      if (claim) begin
        count_q <= '0;
        mode_q  <= bus.i_mode;
        swap_q  <= bus.i_swap;
      end
      if (load) begin
        word_q      <= data_in[31:0];
        count_q     <= count_q + SIZE_WIDTH'(1);
        word_last_q <= (count_q + SIZE_WIDTH'(1)) == bus.i_read_size;
        sub_q       <= 1'b0;
        buf_vld     <= 1'b1;
      end else if (emit) begin
        sub_q <= 1'b1;
        if (final_sub) buf_vld <= 1'b0;
      end
      if (emit) begin
        pix_q  <= pix_nxt;
        last_q <= word_last_q & final_sub;
        rdy_q  <= 1'b1;
      end else if (rdy_q && bus.i_pixel_stb) begin
        last_q <= 1'b0;
        rdy_q  <= 1'b0;
      end
    end

  assign bus.o_red       = pix_q.r;
  assign bus.o_green     = pix_q.g;
  assign bus.o_blue      = pix_q.b;
  assign bus.o_last      = last_q;
  assign bus.o_pixel_rdy = rdy_q;
  assign bus.o_busy      = bus.o_read_act | buf_vld;
endmodule

// File: tb/tb_pixel_reader_packed.sv
// Scoreboard bench for pixel_reader_packed: directed blocks with hand-computed pixels.
module tb_pixel_reader_packed;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_reader_packed_if #(.DATA_WIDTH(32), .SIZE_WIDTH(24), .CHANNEL_WIDTH(8)) bus ();
  pixel_reader_packed #(.DATA_WIDTH(32), .SIZE_WIDTH(24), .CHANNEL_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int          n_chk = 0, n_fail = 0, stb_cnt = 0, pix_cnt = 0;
  logic [31:0] fifo[$];
  logic [24:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  function automatic void expect_pix(input logic [7:0] r, g, b, input logic last);
    exp_q.push_back({r, g, b, last});
  endfunction

  // FIFO model: first-word fall-through, popped on each consumed strobe
  initial begin
    logic take;
    bus.i_read_data = '0;
    forever begin
      @(negedge clk);
      take = !rst && bus.o_read_stb;
      @(posedge clk);
      if (take) begin
        stb_cnt++;
        if (fifo.size() > 0) void'(fifo.pop_front());
      end
      #1;
      bus.i_read_data = (fifo.size() > 0) ? fifo[0] : 32'h0;
    end
  end

  // Pixel monitor
  initial forever begin
    @(negedge clk);
    if (!rst && bus.o_pixel_rdy && bus.i_pixel_stb) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected pixel: got %0h%0h%0h last %0b expected none",
                 bus.o_red, bus.o_green, bus.o_blue, bus.o_last);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        check("pixel", 32'({bus.o_red, bus.o_green, bus.o_blue, bus.o_last}), 32'(e));
        pix_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish expected done");
    $fatal(1);
  end

  task automatic wait_act(input logic val, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step;
      if (bus.o_read_act === val) begin ok = 1'b1; break; end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic claim(input logic mode, swap, input logic [23:0] size);
    bus.i_mode      = mode;
    bus.i_swap      = swap;
    bus.i_read_size = size;
    bus.i_read_rdy  = 1'b1;
    wait_act(1'b1, "claim");
    bus.i_read_rdy  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step;
      if (!bus.o_busy && !bus.o_pixel_rdy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check({name, " idle"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int s0, p0;
    bus.i_mode = 0; bus.i_swap = 0; bus.i_read_rdy = 0; bus.i_read_size = '0;
    bus.i_pixel_stb = 1'b1;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check("reset outputs", 32'({bus.o_read_act, bus.o_read_stb, bus.o_pixel_rdy, bus.o_last,
                                    bus.o_busy, bus.o_red, bus.o_green, bus.o_blue}), 32'd0);
    step; step;
    rst = 1'b0;
    step;

    // 1: RGB888 at full rate
    s0 = stb_cnt;
    fifo.push_back(32'h00FF0000); fifo.push_back(32'h0000FF00); fifo.push_back(32'h000000FF);
    expect_pix(8'hFF, 8'h00, 8'h00, 0); expect_pix(8'h00, 8'hFF, 8'h00, 0); expect_pix(8'h00, 8'h00, 8'hFF, 1);
    claim(0, 0, 24'd3);
    p0 = pix_cnt;
    repeat (5) step;
    check("t1 throughput", 32'(pix_cnt - p0), 32'd3);
    check("t1 act released", 32'(bus.o_read_act), 32'd0);
    wait_idle("t1");
    check("t1 stb", 32'(stb_cnt - s0), 32'd3);

    // 2: RGB565, both half orders
    for (int sw = 0; sw < 2; sw++) begin
      s0 = stb_cnt;
      fifo.push_back(32'h001FF800); fifo.push_back(32'h07E0FFFF);
      if (sw == 0) begin
        expect_pix(8'hFF, 8'h00, 8'h00, 0); expect_pix(8'h00, 8'h00, 8'hFF, 0);
        expect_pix(8'hFF, 8'hFF, 8'hFF, 0); expect_pix(8'h00, 8'hFF, 8'h00, 1);
      end else begin
        expect_pix(8'h00, 8'h00, 8'hFF, 0); expect_pix(8'hFF, 8'h00, 8'h00, 0);
        expect_pix(8'h00, 8'hFF, 8'h00, 0); expect_pix(8'hFF, 8'hFF, 8'hFF, 1);
      end
      claim(1, sw[0], 24'd2);
      wait_idle("t2");
      check("t2 stb", 32'(stb_cnt - s0), 32'd2);
    end

    // 3: back-pressure holds the first pixel
    bus.i_pixel_stb = 1'b0;
    fifo.push_back(32'h07E0F800);
    expect_pix(8'hFF, 8'h00, 8'h00, 0); expect_pix(8'h00, 8'hFF, 8'h00, 1);
    claim(1, 0, 24'd1);
    step; step;
    for (int i = 0; i < 5; i++) begin
      check("t3 frozen", 32'({bus.o_pixel_rdy, bus.o_red, bus.o_green, bus.o_blue, bus.o_last}),
            32'({1'b1, 8'hFF, 8'h00, 8'h00, 1'b0}));
      step;
    end
    bus.i_pixel_stb = 1'b1;
    step;
    check("t3 second", 32'({bus.o_pixel_rdy, bus.o_red, bus.o_green, bus.o_blue, bus.o_last}),
          32'({1'b1, 8'h00, 8'hFF, 8'h00, 1'b1}));
    wait_idle("t3");

    // 4: empty block
    s0 = stb_cnt; p0 = pix_cnt;
    bus.i_read_size = 24'd0;
    bus.i_read_rdy  = 1'b1;
    wait_act(1'b1, "t4 claim");
    step;
    check("t4 release", 32'({bus.o_read_act, bus.o_pixel_rdy}), 32'd0);
    step;
    check("t4 reclaim", 32'(bus.o_read_act), 32'd1);
    bus.i_read_rdy = 1'b0;
    step;
    check("t4 released", 32'(bus.o_read_act), 32'd0);
    check("t4 no stb/pixel", 32'((stb_cnt - s0) + (pix_cnt - p0)), 32'd0);

    // 5: reset mid-block, then a fresh block
    s0 = stb_cnt;
    for (int i = 0; i < 8; i++) begin
      fifo.push_back(32'h00102030 + 32'(i) * 32'h00010101);
      expect_pix(8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), i == 7);
    end
    claim(0, 0, 24'd8);
    for (int i = 0; i < 50 && (stb_cnt - s0) < 3; i++) step;
    check("t5 three stb", 32'(stb_cnt - s0), 32'd3);
    #2 rst = 1'b1;
    #1 check("t5 async reset", 32'({bus.o_read_act, bus.o_read_stb, bus.o_pixel_rdy, bus.o_last,
                                     bus.o_busy, bus.o_red, bus.o_green, bus.o_blue}), 32'd0);
    fifo.delete(); exp_q.delete();
    step; step;
    rst = 1'b0;
    s0 = stb_cnt;
    fifo.push_back(32'h00AA5511); fifo.push_back(32'h00123456);
    expect_pix(8'hAA, 8'h55, 8'h11, 0); expect_pix(8'h12, 8'h34, 8'h56, 1);
    claim(0, 0, 24'd2);
    wait_idle("t5");
    check("t5 stb", 32'(stb_cnt - s0), 32'd2);

    // 6: back-to-back blocks
    s0 = stb_cnt;
    fifo.push_back(32'h00C0FFEE); fifo.push_back(32'h00010203);
    fifo.push_back(32'h00FEDCBA); fifo.push_back(32'h00808080);
    expect_pix(8'hC0, 8'hFF, 8'hEE, 0); expect_pix(8'h01, 8'h02, 8'h03, 1);
    expect_pix(8'hFE, 8'hDC, 8'hBA, 0); expect_pix(8'h80, 8'h80, 8'h80, 1);
    bus.i_mode = 0; bus.i_read_size = 24'd2; bus.i_read_rdy = 1'b1;
    wait_act(1'b1, "t6 claim");
    wait_act(1'b0, "t6 release");
    step;
    check("t6 reclaim", 32'(bus.o_read_act), 32'd1);
    bus.i_read_rdy = 1'b0;
    wait_idle("t6");
    check("t6 stb", 32'(stb_cnt - s0), 32'd4);

    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
